// File: rtl/pc_unit.sv
// Program counter: holds the current PC, steps by PC_STEP or loads a word-aligned target.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.

module pc_unit_adder #(
  parameter logic [31:0] STEP = 32'd4
) (
  input  logic [31:0] i_a,
  output logic [31:0] o_sum
);
  // Only the low 32 bits are kept, so the sum wraps and the carry out is dropped.
  assign o_sum = i_a + STEP;
endmodule

module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pc_sel,
  input  logic [31:0] target,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_step;
  logic [31:0] w_target_aligned;
  logic [31:0] w_pc_next;
  logic        w_trap;

  pc_unit_adder #(.STEP(PC_STEP)) u_adder (
    .i_a   (r_pc),
    .o_sum (w_pc_step)
  );

  // The mask keeps every target bit in use, including in the build without the trap.
  assign w_target_aligned = target & ~32'h0000_0003;

`ifdef PC_MISALIGN_TRAP_EN
  assign w_trap = pc_sel && (target[1:0] != 2'b00);
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_pc_next = w_pc_step;
    if (pc_sel) begin
      w_pc_next = w_target_aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
    end else if (en && !w_trap) begin
      r_pc <= w_pc_next;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic r_misaligned;

  // Any enabled update rewrites the flag, so a trap is visible for one enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misaligned <= 1'b0;
    end else if (en) begin
      r_misaligned <= w_trap;
    end
  end

  assign misaligned = r_misaligned;
`else
  assign misaligned = 1'b0;
`endif

  assign pc_out   = r_pc;
  assign pc_plus4 = w_pc_step;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; the misalignment expectations follow
// whether PC_MISALIGN_TRAP_EN is defined for the build.

module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic        pc_sel;
  logic [31:0] target;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misaligned;

  int n_checks;
  int n_fail;

  pc_unit dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pc_sel     (pc_sel),
    .target     (target),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are changed 1 time unit after a rising edge and outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; pc_sel = 1'b0; target = 32'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; pc_sel = 1'b1; target = 32'h0000_0557;
    step();
    n_checks++;
    if (pc_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0);
    end
    n_checks++;
    if (misaligned !== 1'b0) begin
      n_fail++; $display("FAIL reset_misaligned: got %b expected 0", misaligned);
    end
    n_checks++;
    if (pc_plus4 !== 32'h4) begin
      n_fail++; $display("FAIL reset_plus4: got %h expected %h", pc_plus4, 32'h4);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    en = 1'b1; pc_sel = 1'b0; target = 32'hDEAD_BEEF;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_checks++;
      if (pc_out !== 32'(4 * i)) begin
        n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc_out, 32'(4 * i));
      end
      n_checks++;
      if (pc_plus4 !== 32'(4 * i + 4)) begin
        n_fail++; $display("FAIL seq_plus4[%0d]: got %h expected %h", i, pc_plus4, 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    en = 1'b1; pc_sel = 1'b0;
    step();
    step();
    n_checks++;
    if (pc_out !== 32'h8) begin
      n_fail++; $display("FAIL stall_setup: got %h expected %h", pc_out, 32'h8);
    end
    en = 1'b0; pc_sel = 1'b1; target = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (pc_out !== 32'h8) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, pc_out, 32'h8);
      end
    end
    en = 1'b1; pc_sel = 1'b0;
    step();
    n_checks++;
    if (pc_out !== 32'hC) begin
      n_fail++; $display("FAIL stall_resume: got %h expected %h", pc_out, 32'hC);
    end
  endtask

  task automatic test_branch();
    en = 1'b1; pc_sel = 1'b1; target = 32'h0000_0100;
    step();
    n_checks++;
    if (pc_out !== 32'h100) begin
      n_fail++; $display("FAIL branch_taken: got %h expected %h", pc_out, 32'h100);
    end
    pc_sel = 1'b0;
    step();
    n_checks++;
    if (pc_out !== 32'h104) begin
      n_fail++; $display("FAIL branch_seq1: got %h expected %h", pc_out, 32'h104);
    end
    step();
    n_checks++;
    if (pc_out !== 32'h108) begin
      n_fail++; $display("FAIL branch_seq2: got %h expected %h", pc_out, 32'h108);
    end
  endtask

  task automatic test_wrap();
    en = 1'b1; pc_sel = 1'b1; target = 32'hFFFF_FFFC;
    step();
    n_checks++;
    if (pc_out !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_load: got %h expected %h", pc_out, 32'hFFFF_FFFC);
    end
    n_checks++;
    if (pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL wrap_plus4: got %h expected %h", pc_plus4, 32'h0);
    end
    pc_sel = 1'b0;
    step();
    n_checks++;
    if (pc_out !== 32'h0) begin
      n_fail++; $display("FAIL wrap_pc: got %h expected %h", pc_out, 32'h0);
    end
    n_checks++;
    if (misaligned !== 1'b0) begin
      n_fail++; $display("FAIL wrap_misaligned: got %b expected 0", misaligned);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic        exp_mis;
    en = 1'b1; pc_sel = 1'b1; target = 32'h0000_0040;
    step();
    target = 32'h0000_0102;
`ifdef PC_MISALIGN_TRAP_EN
    exp_pc = 32'h40; exp_mis = 1'b1;
`else
    exp_pc = 32'h100; exp_mis = 1'b0;
`endif
    step();
    n_checks++;
    if (pc_out !== exp_pc) begin
      n_fail++; $display("FAIL misalign_pc: got %h expected %h", pc_out, exp_pc);
    end
    n_checks++;
    if (misaligned !== exp_mis) begin
      n_fail++; $display("FAIL misalign_flag: got %b expected %b", misaligned, exp_mis);
    end
    en = 1'b0;
    step();
    n_checks++;
    if (pc_out !== exp_pc || misaligned !== exp_mis) begin
      n_fail++;
      $display("FAIL misalign_stall: got pc=%h mis=%b expected pc=%h mis=%b",
               pc_out, misaligned, exp_pc, exp_mis);
    end
    en = 1'b1; pc_sel = 1'b0;
    step();
    n_checks++;
    if (pc_out !== exp_pc + 32'h4 || misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_clear: got pc=%h mis=%b expected pc=%h mis=0",
               pc_out, misaligned, exp_pc + 32'h4);
    end
  endtask

  task automatic test_reset_override();
    en = 1'b1; pc_sel = 1'b1; target = 32'h0000_0020;
    step();
    n_checks++;
    if (pc_out !== 32'h20) begin
      n_fail++; $display("FAIL override_setup: got %h expected %h", pc_out, 32'h20);
    end
    rst = 1'b1; pc_sel = 1'b1; target = 32'h0000_0200;
    step();
    n_checks++;
    if (pc_out !== 32'h0 || misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL override_rst: got pc=%h mis=%b expected pc=0 mis=0", pc_out, misaligned);
    end
    rst = 1'b0; pc_sel = 1'b0;
    step();
    step();
    rst = 1'b1; en = 1'b0;
    step();
    n_checks++;
    if (pc_out !== 32'h0) begin
      n_fail++; $display("FAIL override_stall_rst: got %h expected %h", pc_out, 32'h0);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (pc_out !== 32'h0) begin
      n_fail++; $display("FAIL post_rst_hold: got %h expected %h", pc_out, 32'h0);
    end
    en = 1'b1;
    step();
    n_checks++;
    if (pc_out !== 32'h4) begin
      n_fail++; $display("FAIL post_rst_first_inc: got %h expected %h", pc_out, 32'h4);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; en = 1'b0; pc_sel = 1'b0; target = 32'h0;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_wrap();
    test_misalign();
    test_reset_override();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
